// File: rtl/sqrt_pkg.sv
// Shared types and constants for the iterative square-root block.
// isqrt_ref is a plain software-style reference usable from benches.
package sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } sqrt_state_t;

    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_NEAREST = 1;

    function automatic longint unsigned isqrt_ref(input longint unsigned v);
        longint unsigned rem_v;
        longint unsigned root_v;
        longint unsigned trial;
        rem_v  = 64'd0;
        root_v = 64'd0;
        for (int i = 31; i >= 0; i--) begin
            rem_v = (rem_v << 2) | ((v >> (2 * i)) & 64'd3);
            trial = (root_v << 2) | 64'd1;
            if (rem_v >= trial) begin
                rem_v  = rem_v - trial;
                root_v = (root_v << 1) | 64'd1;
            end else begin
                root_v = root_v << 1;
            end
        end
        return root_v;
    endfunction

endpackage

// File: rtl/sqrt_iter_param_step.sv
// One digit of the restoring square root: bring down two operand bits,
// try subtracting (root<<2)|1, and append the resulting root bit.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH/2+1:0] acc,
    input  logic [WIDTH/2-1:0] root,
    input  logic [1:0]         bits,
    output logic [WIDTH/2+1:0] acc_nxt,
    output logic [WIDTH/2-1:0] root_nxt
);

    localparam int HALF  = WIDTH / 2;
    localparam int ACC_W = HALF + 2;

    logic [ACC_W-1:0] acc_sh;
    logic [ACC_W-1:0] trial;
    logic             take;

    // The shifted-out top bits of acc are always zero because rem <= 2*root.
    always_comb begin
        acc_sh   = (acc << 2) | ACC_W'(bits);
        trial    = {root, 2'b01};
        take     = (acc_sh >= trial);
        acc_nxt  = take ? (acc_sh - trial) : acc_sh;
        root_nxt = (root << 1) | HALF'(take);
    end

endmodule

// File: rtl/sqrt_iter_param.sv
// Iterative integer square root, one root bit per clock, with optional
// round-to-nearest output and a floor-relative remainder.
module sqrt_iter_param
    import sqrt_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ROUND_MODE = ROUND_FLOOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] out,
    output logic [WIDTH/2:0]   rem,
    output logic               eop
);

    localparam int HALF  = WIDTH / 2;
    localparam int ACC_W = HALF + 2;
    localparam int REM_W = HALF + 1;
    localparam int CNT_W = $clog2(HALF);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("sqrt_iter_param: WIDTH must be even and in 4..64");
    end
    if (ROUND_MODE != ROUND_FLOOR && ROUND_MODE != ROUND_NEAREST) begin : g_bad_round
        $error("sqrt_iter_param: ROUND_MODE must be 0 or 1");
    end

    sqrt_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             eop_q;

    logic [WIDTH-1:0] opnd_p0;
    logic [ACC_W-1:0] acc_p0;
    logic [HALF-1:0]  root_p0;
    logic [ACC_W-1:0] acc_nxt;
    logic [HALF-1:0]  root_nxt;
    logic [REM_W-1:0] rem_p0;

    // Round up only when the remainder says we are past the midpoint, and
    // never past the largest representable root.
    function automatic logic [HALF-1:0] round_root(input logic [HALF-1:0] r,
                                                   input logic [REM_W-1:0] rm);
        if (ROUND_MODE == ROUND_NEAREST && rm > {1'b0, r} && r != '1)
            return r + 1'b1;
        return r;
    endfunction

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign eop       = eop_q;
    assign rem_p0    = REM_W'(acc_p0);
    assign out       = out_valid ? round_root(root_p0, rem_p0) : '0;
    assign rem       = out_valid ? rem_p0 : '0;

    sqrt_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc_p0),
        .root    (root_p0),
        .bits    (opnd_p0[WIDTH-1 -: 2]),
        .acc_nxt (acc_nxt),
        .root_nxt(root_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            eop_q <= 1'b0;
        end else begin
            eop_q <= (state == S_CALC) && (cnt == '0);
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= S_CALC;
                        cnt   <= CNT_W'(HALF - 1);
                    end
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // p0: operand shift register and partial remainder/root
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            opnd_p0 <= val;
            acc_p0  <= '0;
            root_p0 <= '0;
        end else if (state == S_CALC) begin
            opnd_p0 <= opnd_p0 << 2;
            acc_p0  <= acc_nxt;
            root_p0 <= root_nxt;
        end
    end

endmodule

// File: tb/tb_sqrt_iter_param.sv
// Directed and randomised checks of sqrt_iter_param: 16-bit floor and
// round-to-nearest instances sharing stimulus, plus a 32-bit floor instance.
module tb_sqrt_iter_param;

    logic        clk;
    logic        rst;

    logic        in_valid16;
    logic [15:0] val16;
    logic        out_ready16;
    logic        in_ready_f, out_valid_f, eop_f;
    logic [7:0]  out_f;
    logic [8:0]  rem_f;
    logic        in_ready_r, out_valid_r, eop_r;
    logic [7:0]  out_r;
    logic [8:0]  rem_r;

    logic        in_valid32;
    logic [31:0] val32;
    logic        out_ready32;
    logic        in_ready32, out_valid32, eop32;
    logic [15:0] out32;
    logic [16:0] rem32;

    int n_chk;
    int n_pass;

    sqrt_iter_param #(.WIDTH(16), .ROUND_MODE(0)) dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_f),
        .val(val16), .out_valid(out_valid_f), .out_ready(out_ready16),
        .out(out_f), .rem(rem_f), .eop(eop_f)
    );

    sqrt_iter_param #(.WIDTH(16), .ROUND_MODE(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_r),
        .val(val16), .out_valid(out_valid_r), .out_ready(out_ready16),
        .out(out_r), .rem(rem_r), .eop(eop_r)
    );

    sqrt_iter_param #(.WIDTH(32), .ROUND_MODE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .val(val32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out(out32), .rem(rem32), .eop(eop32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    // One 16-bit transaction on the shared bus; stall = cycles out_ready stays low.
    task automatic do16(input logic [15:0] v, input int stall,
                        output logic [7:0] fo, output logic [8:0] frm,
                        output logic [7:0] ro, output logic [8:0] rrm,
                        output logic r_ok, output int lat, output int neop);
        int guard;
        val16       = v;
        in_valid16  = 1'b1;
        out_ready16 = (stall == 0);
        guard = 0;
        while (!in_ready_f && guard < 50) begin step(); guard++; end
        if (guard >= 50) chk("in_ready_wait16", 0, 1);
        step();
        in_valid16 = 1'b0;
        val16      = ~v;
        lat  = 0;
        neop = 0;
        while (!out_valid_f && lat < 100) begin
            step();
            lat++;
            if (eop_f) neop++;
        end
        fo   = out_f;
        frm  = rem_f;
        ro   = out_r;
        rrm  = rem_r;
        r_ok = out_valid_r && eop_r && !in_ready_r;
        for (int i = 0; i < stall; i++) begin
            step();
            if (eop_f) neop++;
        end
        out_ready16 = 1'b1;
        step();
        if (eop_f) neop++;
        out_ready16 = 1'b0;
    endtask

    task automatic do32(input logic [31:0] v, input int stall,
                        output logic [15:0] o, output logic [16:0] rm,
                        output int lat, output int neop);
        int guard;
        val32       = v;
        in_valid32  = 1'b1;
        out_ready32 = (stall == 0);
        guard = 0;
        while (!in_ready32 && guard < 50) begin step(); guard++; end
        if (guard >= 50) chk("in_ready_wait32", 0, 1);
        step();
        in_valid32 = 1'b0;
        val32      = ~v;
        lat  = 0;
        neop = 0;
        while (!out_valid32 && lat < 100) begin
            step();
            lat++;
            if (eop32) neop++;
        end
        o  = out32;
        rm = rem32;
        for (int i = 0; i < stall; i++) begin
            step();
            if (eop32) neop++;
        end
        out_ready32 = 1'b1;
        step();
        if (eop32) neop++;
        out_ready32 = 1'b0;
    endtask

    typedef struct {
        logic [15:0] v;
        logic [7:0]  fo;
        logic [8:0]  rm;
        logic [7:0]  ro;
        int          stall;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [7:0]  fo, ro;
        logic [8:0]  frm, rrm;
        logic        r_ok;
        int          lat, neop, cnt;
        logic        stable;
        logic [15:0] o32;
        logic [16:0] rm32;
        logic [31:0] v32;
        longint unsigned r, m;
        real         rv;
        int          eop_tot;

        n_chk = 0;
        n_pass = 0;

        tbl[0]  = '{16'd0,     8'd0,   9'd0,   8'd0,   0};
        tbl[1]  = '{16'd1,     8'd1,   9'd0,   8'd1,   1};
        tbl[2]  = '{16'd2,     8'd1,   9'd1,   8'd1,   0};
        tbl[3]  = '{16'd3,     8'd1,   9'd2,   8'd2,   2};
        tbl[4]  = '{16'd24,    8'd4,   9'd8,   8'd5,   0};
        tbl[5]  = '{16'd30,    8'd5,   9'd5,   8'd5,   3};
        tbl[6]  = '{16'd31,    8'd5,   9'd6,   8'd6,   0};
        tbl[7]  = '{16'd99,    8'd9,   9'd18,  8'd10,  1};
        tbl[8]  = '{16'd1024,  8'd32,  9'd0,   8'd32,  0};
        tbl[9]  = '{16'd65535, 8'd255, 9'd510, 8'd255, 5};
        tbl[10] = '{16'd65534, 8'd255, 9'd509, 8'd255, 0};
        tbl[11] = '{16'd65024, 8'd254, 9'd508, 8'd255, 2};
        tbl[12] = '{16'd20,    8'd4,   9'd4,   8'd4,   0};
        tbl[13] = '{16'd21,    8'd4,   9'd5,   8'd5,   1};
        tbl[14] = '{16'd65025, 8'd255, 9'd0,   8'd255, 0};

        rst = 1'b1;
        in_valid16 = 1'b0; val16 = '0; out_ready16 = 1'b0;
        in_valid32 = 1'b0; val32 = '0; out_ready32 = 1'b0;
        step();
        step();
        chk("rst_in_ready",  in_ready_f,  0);
        chk("rst_out_valid", out_valid_f, 0);
        chk("rst_eop",       eop_f,       0);
        chk("rst_out",       out_f,       0);
        chk("rst_rem",       rem_f,       0);
        chk("rst_in_ready32", in_ready32, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready_f, 1);

        for (int i = 0; i < 15; i++) begin
            do16(tbl[i].v, tbl[i].stall, fo, frm, ro, rrm, r_ok, lat, neop);
            chk($sformatf("vec%0d_out", i),       fo,   tbl[i].fo);
            chk($sformatf("vec%0d_rem", i),       frm,  tbl[i].rm);
            chk($sformatf("vec%0d_round", i),     ro,   tbl[i].ro);
            chk($sformatf("vec%0d_round_rem", i), rrm,  tbl[i].rm);
            chk($sformatf("vec%0d_round_hs", i),  r_ok, 1);
            chk($sformatf("vec%0d_latency", i),   lat,  8);
            chk($sformatf("vec%0d_eop_count", i), neop, 1);
        end

        for (int v = 4; v <= 300; v++) begin
            r = 0;
            while ((r + 1) * (r + 1) <= longint'(v)) r++;
            m = longint'(v) - r * r;
            do16(16'(v), 0, fo, frm, ro, rrm, r_ok, lat, neop);
            chk($sformatf("seq%0d_out", v),   fo,  r);
            chk($sformatf("seq%0d_rem", v),   frm, m);
            chk($sformatf("seq%0d_round", v), ro,  (m > r && r < 255) ? r + 1 : r);
        end

        // Consumer stalls for 20 cycles while a new operand is offered
        val16 = 16'd99; in_valid16 = 1'b1; out_ready16 = 1'b0;
        cnt = 0;
        while (!in_ready_f && cnt < 50) begin step(); cnt++; end
        step();
        val16 = 16'd5;
        lat = 0; neop = 0;
        while (!out_valid_f && lat < 100) begin step(); lat++; if (eop_f) neop++; end
        chk("stall_latency", lat, 8);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (eop_f) neop++;
            if (out_f != 8'd9 || rem_f != 9'd18 || !out_valid_f || in_ready_f) stable = 1'b0;
        end
        chk("stall_hold", stable, 1);
        chk("stall_eop_count", neop, 1);
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        step();
        out_ready16 = 1'b0;
        chk("stall_release_valid", out_valid_f, 0);
        do16(16'd49, 0, fo, frm, ro, rrm, r_ok, lat, neop);
        chk("after_stall_out", fo, 7);
        chk("after_stall_rem", frm, 0);

        // Reset three cycles into a calculation discards it
        val16 = 16'd1000; in_valid16 = 1'b1; out_ready16 = 1'b1;
        cnt = 0;
        while (!in_ready_f && cnt < 50) begin step(); cnt++; end
        step();
        in_valid16 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid_f, 0);
        chk("midrst_in_ready",  in_ready_f,  1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (eop_f || out_valid_f) cnt++;
        end
        chk("midrst_no_result", cnt, 0);
        do16(16'd1024, 0, fo, frm, ro, rrm, r_ok, lat, neop);
        chk("midrst_next_out", fo, 32);
        chk("midrst_next_rem", frm, 0);

        // Reset and in_valid together: operand must not be taken
        rst = 1'b1; in_valid16 = 1'b1; val16 = 16'd9;
        #1;
        chk("rst_vs_valid_ready", in_ready_f, 0);
        step();
        rst = 1'b0; in_valid16 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid_f || eop_f) cnt++;
        end
        chk("rst_vs_valid_no_result", cnt, 0);

        eop_tot = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 0)            v32 = 32'd0;
            else if (i == 1)       v32 = 32'd1;
            else if (i == 2)       v32 = 32'hFFFF_FFFF;
            else if (i % 4 == 3) begin
                v32 = 32'($urandom_range(0, 65535));
                v32 = v32 * v32;
            end else               v32 = $urandom;
            rv = v32;
            r = longint'($sqrt(rv));
            while (r * r > longint'(v32)) r--;
            while ((r + 1) * (r + 1) <= longint'(v32)) r++;
            m = longint'(v32) - r * r;
            do32(v32, $urandom_range(0, 3), o32, rm32, lat, neop);
            eop_tot += neop;
            chk($sformatf("w32_%0d_out v=%0d", i, v32), o32, r);
            chk($sformatf("w32_%0d_rem v=%0d", i, v32), rm32, m);
            chk($sformatf("w32_%0d_latency", i), lat, 16);
        end
        chk("w32_eop_total", eop_tot, 2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
